// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: shares the register-file write side between scalar writeback
// and a buffered 8-lane vector writeback, with a starvation-forced vector drain.
module rf_write_scheduler #(
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [4:0]                 s_addr,
    input  logic [31:0]                s_data,
    input  logic                       v_valid,
    output logic                       v_ready,
    input  logic [4:0]                 v_addr,
    input  logic [255:0]               v_data,
    input  logic [4:0]                 id_rs_addr,
    input  logic [4:0]                 id_rt_addr,
    input  logic                       id_vec_read,
    output logic                       stall_id,
    output logic                       wb_hold,
    output logic                       rf_write,
    output logic [4:0]                 rf_write_addr,
    output logic [31:0]                rf_write_data,
    output logic                       rf_vwrite,
    output logic [4:0]                 rf_vwrite_addr,
    output logic [255:0]               rf_vwrite_data,
    output logic [$clog2(DEPTH):0]     v_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE + 1);

    typedef enum logic {IDLE, FORCE} state_t;

    state_t         state;
    logic [4:0]     mem_addr [DEPTH];
    logic [255:0]   mem_data [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [WW-1:0]  wait_cnt;
    logic           push, pop, grant_s, empty, starve, fifo_hit;

    function automatic logic reads(input logic [4:0] a);
        return a == id_rs_addr || a == id_rt_addr;
    endfunction

    assign v_ready = (v_count < CW'(DEPTH)) && !rst;
    assign push    = v_valid && v_ready;
    assign empty   = v_count == '0;
    assign grant_s = s_valid && !wb_hold;
    assign pop     = !grant_s && !empty;
    assign starve  = !empty && grant_s && wait_cnt == WW'(STARVE - 1);

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            fifo_hit = fifo_hit || (({1'b0, PW'(i) - rd_ptr} < v_count) && reads(mem_addr[i]));
    end

    assign stall_id = !rst && id_vec_read &&
                      (fifo_hit || (rf_vwrite && reads(rf_vwrite_addr)) || (v_valid && reads(v_addr)));

    always_ff @(posedge clk)
        if (push) begin
            mem_addr[wr_ptr] <= v_addr;
            mem_data[wr_ptr] <= v_data;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wb_hold        <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            v_count        <= '0;
            wait_cnt       <= '0;
            rf_write       <= 1'b0;
            rf_write_addr  <= '0;
            rf_write_data  <= '0;
            rf_vwrite      <= 1'b0;
            rf_vwrite_addr <= '0;
            rf_vwrite_data <= '0;
        end else begin
            rf_write  <= grant_s;
            rf_vwrite <= pop;
            if (grant_s) begin
                rf_write_addr <= s_addr;
                rf_write_data <= s_data;
            end
            if (pop) begin
                rf_vwrite_addr <= mem_addr[rd_ptr];
                rf_vwrite_data <= mem_data[rd_ptr];
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            v_count  <= v_count + CW'(push) - CW'(pop);
            wait_cnt <= (pop || empty) ? '0 : grant_s ? wait_cnt + 1'b1 : wait_cnt;
            state    <= (state == IDLE && starve) ? FORCE : IDLE;
            wb_hold  <= state == IDLE && starve;
        end
    end
endmodule
